avalon_burst_arbiter: RTL and testbench
=======================================

// Module: avalon_burst_arbiter
// PURPOSE
//  Shares one Avalon-MM agent port (SDRAM controller) between NREQ burst-capable hosts.
//  Typical hosts: the display frame reader (host 0) and a frame-buffer writer.
//  Grants are burst-atomic: one host owns the agent from command until its last read beat
//  returns or its last write beat is accepted. Arbitration is round-robin.
// PARAMETERS
//  NREQ  2   number of requesting hosts (2..8)
//  AW    32  byte address width
//  DW    32  data width
//  BW    5   burstcount width (max burst 2**(BW-1))
// PORTS
//  clk              in   1         single clock, all logic on its rising edge
//  rst_n            in   1         asynchronous, active-low reset
//  h_read           in   NREQ      per-host read request
//  h_write          in   NREQ      per-host write request
//  h_address        in   NREQ*AW   per-host address, host i at [i*AW +: AW]
//  h_burstcount     in   NREQ*BW   per-host burst length
//  h_writedata      in   NREQ*DW   per-host write data
//  h_waitrequest    out  NREQ      per-host stall
//  h_readdata       out  DW        shared read data, qualified by h_readdatavalid
//  h_readdatavalid  out  NREQ      one-hot read beat valid to the owning host
//  a_read, a_write  out  1         agent command strobes
//  a_address        out  AW        agent address
//  a_burstcount     out  BW        agent burst length
//  a_writedata      out  DW        agent write data
//  a_waitrequest    in   1         agent stall
//  a_readdata       in   DW        agent read data
//  a_readdatavalid  in   1         agent read beat valid
//  grant            out  NREQ      one-hot current owner (all 0 in IDLE)
//  err_stray        out  1         sticky: readdatavalid received outside RD_DATA
// BEHAVIOUR
//  Reset: state=IDLE; grant=0; a_read=a_write=0; h_waitrequest=all 1; h_readdatavalid=0;
//   beat counter=0; err_stray=0; last_owner=NREQ-1, so host 0 wins first.
//  FSM states: IDLE, RD_CMD, RD_DATA, WR_BURST.
//  IDLE: all h_waitrequest=1. Host i requests when h_read[i]|h_write[i].
//   The winner is the first requester scanning from last_owner+1 upward, modulo NREQ.
//   grant is registered. Next state is RD_CMD if h_read[winner], else WR_BURST.
//   If a host asserts both read and write, read wins.
//  Command path is combinational pass-through from the granted host:
//   a_* = host fields gated by the state; h_waitrequest[owner] = a_waitrequest;
//   non-owners see h_waitrequest=1.
//  Latency: request sampled in IDLE at cycle N; the agent sees the command at cycle N+1.
//  RD_CMD: a_read=1. On !a_waitrequest, latch burstcount into beats_left and go to RD_DATA.
//  RD_DATA: a_read=0; owner h_waitrequest=1. Each a_readdatavalid routes to
//   h_readdatavalid[owner] in the same cycle; h_readdata=a_readdata always.
//   beats_left decrements per beat. On the beat with beats_left==1: go to IDLE,
//   set last_owner=owner, clear grant.
//  WR_BURST: a_write=h_write[owner]. On the first accepted beat (write & !waitrequest),
//   latch burstcount-1 remaining; count later accepted beats. On the last accepted beat:
//   go to IDLE, set last_owner=owner. A single-beat burst completes on its first accept.
//   Address and burstcount are taken from the first beat only.
//  burstcount==0 is treated as 1 (read and write).
//  a_readdatavalid in any state other than RD_DATA: beat dropped, no host strobe,
//   err_stray set (cleared only by reset).
//  Counters are BW bits; no wrap is possible because the maximum burst fits.
//  Reset mid-burst: the FSM aborts to IDLE with reset values. Outstanding agent beats that
//   arrive afterwards set err_stray.
//  Consecutive bursts: one IDLE cycle between owners. A host may re-win immediately only
//   if no other host requests.
// CONFIGURATION
//  AVALON_ARB_PRIORITY_EN defined: host 0 has strict priority in IDLE; if host 0 requests,
//   it wins regardless of last_owner. Other hosts stay round-robin among themselves.
//  Not defined: pure round-robin as above.
// TESTING
//  1. Hosts 0 and 1 each read burst 16 continuously -> grant alternates 0,1,0,1; each host
//     gets exactly 16 h_readdatavalid pulses per grant.
//  2. Host 1 writes burst 4 with a_waitrequest high for 3 cycles on beat 2 -> exactly 4 beats
//     accepted, data order preserved; IDLE follows the 4th accept.
//  3. Host 0 read (burst 8) while host 1 write is pending -> host 1 waitrequest stays 1 until
//     the 8th host 0 beat, then host 1 is granted 2 cycles later.
//  4. a_readdatavalid pulsed in IDLE -> no h_readdatavalid; err_stray=1 and stays 1.
//  5. rst_n low after the 3rd of 16 read beats -> outputs return to reset values;
//     remaining beats set err_stray; the next grant goes to host 0.
//  6. AVALON_ARB_PRIORITY_EN defined, both hosts always requesting -> grant is always host 0;
//     undefined -> alternates.

Source files
------------

// File: rtl/avalon_burst_arbiter.sv
// Round-robin, burst-atomic arbiter sharing one Avalon-MM agent between NREQ hosts.
// Define AVALON_ARB_PRIORITY_EN to give host 0 strict priority over the round-robin hosts.
module avalon_burst_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int BW   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    h_read,
  input  logic [NREQ-1:0]    h_write,
  input  logic [NREQ*AW-1:0] h_address,
  input  logic [NREQ*BW-1:0] h_burstcount,
  input  logic [NREQ*DW-1:0] h_writedata,
  output logic [NREQ-1:0]    h_waitrequest,
  output logic [DW-1:0]      h_readdata,
  output logic [NREQ-1:0]    h_readdatavalid,
  output logic               a_read,
  output logic               a_write,
  output logic [AW-1:0]      a_address,
  output logic [BW-1:0]      a_burstcount,
  output logic [DW-1:0]      a_writedata,
  input  logic               a_waitrequest,
  input  logic [DW-1:0]      a_readdata,
  input  logic               a_readdatavalid,
  output logic [NREQ-1:0]    grant,
  output logic               err_stray
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_BURST} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, last_owner, winner;
  logic [OW:0]     scan_idx;
  logic [NREQ-1:0] req;
  logic            any_req;
  logic [BW-1:0]   beats_left, bc_eff;
  logic            wr_started, wr_accept, wr_last;

  logic [AW-1:0] addr_arr [NREQ];
  logic [BW-1:0] bc_arr   [NREQ];
  logic [DW-1:0] wd_arr   [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = h_address[i*AW +: AW];
    assign bc_arr[i]   = h_burstcount[i*BW +: BW];
    assign wd_arr[i]   = h_writedata[i*DW +: DW];
  end

  assign req     = h_read | h_write;
  assign any_req = |req;
  // A zero burstcount is served as a single beat.
  assign bc_eff    = (bc_arr[owner] == '0) ? BW'(1) : bc_arr[owner];
  assign wr_accept = (state == WR_BURST) && h_write[owner] && !a_waitrequest;
  assign wr_last   = wr_started ? (beats_left == BW'(1)) : (bc_eff == BW'(1));

  // Scan from last_owner+1 upward; the smallest offset is assigned last and wins.
  always_comb begin
    winner   = last_owner;
    scan_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = {1'b0, last_owner} + (OW+1)'(k);
      if (scan_idx >= (OW+1)'(NREQ)) scan_idx = scan_idx - (OW+1)'(NREQ);
      if (req[scan_idx[OW-1:0]]) winner = scan_idx[OW-1:0];
    end
`ifdef AVALON_ARB_PRIORITY_EN
    if (req[0]) winner = '0;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_req) state_nxt = h_read[winner] ? RD_CMD : WR_BURST;
      RD_CMD:   if (!a_waitrequest) state_nxt = RD_DATA;
      RD_DATA:  if (a_readdatavalid && beats_left == BW'(1)) state_nxt = IDLE;
      WR_BURST: if (wr_accept && wr_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_read          = (state == RD_CMD);
    a_write         = (state == WR_BURST) && h_write[owner];
    a_address       = '0;
    a_burstcount    = '0;
    a_writedata     = '0;
    h_waitrequest   = '1;
    h_readdatavalid = '0;
    if (state != IDLE) begin
      a_address    = addr_arr[owner];
      a_burstcount = bc_arr[owner];
      a_writedata  = wd_arr[owner];
    end
    if (state == RD_CMD || state == WR_BURST) h_waitrequest[owner] = a_waitrequest;
    if (state == RD_DATA) h_readdatavalid[owner] = a_readdatavalid;
  end

  assign h_readdata = a_readdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      owner      <= '0;
      last_owner <= OW'(NREQ-1);
      beats_left <= '0;
      wr_started <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner <= winner;
          grant <= NREQ'(1) << winner;
        end
        RD_CMD: if (!a_waitrequest) beats_left <= bc_eff;
        RD_DATA: if (a_readdatavalid) begin
          beats_left <= beats_left - BW'(1);
          if (beats_left == BW'(1)) begin
            last_owner <= owner;
            grant      <= '0;
          end
        end
        WR_BURST: if (wr_accept) begin
          // Remaining-beat count comes from the first beat's burstcount only.
          if (!wr_started) begin
            beats_left <= bc_eff - BW'(1);
            wr_started <= 1'b1;
          end else begin
            beats_left <= beats_left - BW'(1);
          end
          if (wr_last) begin
            last_owner <= owner;
            grant      <= '0;
            wr_started <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_stray <= 1'b0;
    else if (a_readdatavalid && state != RD_DATA) err_stray <= 1'b1;
  end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Scoreboard bench for avalon_burst_arbiter with a behavioural SDRAM-like agent.
module tb_avalon_burst_arbiter;
  localparam int NREQ = 2, AW = 32, DW = 32, BW = 5;

  logic clk, rst_n;
  logic [NREQ-1:0]    h_read, h_write, h_waitrequest, h_readdatavalid, grant;
  logic [NREQ*AW-1:0] h_address;
  logic [NREQ*BW-1:0] h_burstcount;
  logic [NREQ*DW-1:0] h_writedata;
  logic [DW-1:0]      h_readdata, a_writedata, a_readdata;
  logic               a_read, a_write, a_waitrequest, a_readdatavalid, err_stray;
  logic [AW-1:0]      a_address;
  logic [BW-1:0]      a_burstcount;

  avalon_burst_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_read(h_read), .h_write(h_write), .h_address(h_address),
    .h_burstcount(h_burstcount), .h_writedata(h_writedata),
    .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
    .h_readdatavalid(h_readdatavalid),
    .a_read(a_read), .a_write(a_write), .a_address(a_address),
    .a_burstcount(a_burstcount), .a_writedata(a_writedata),
    .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .grant(grant), .err_stray(err_stray)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  logic [31:0] exp_rd0[$], exp_rd1[$], exp_wr[$];
  logic [31:0] ag_addr[$];
  int          ag_len[$];
  int          ag_beat = 0, stall_cnt = 0, stall_after = -1, wr_accepts = 0;
  logic        inject_stray = 1'b0;
  int          rd_cnt0 = 0, rd_cnt1 = 0, last_rd_cyc0 = 0, cur_beats = 0;
  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] grant_log[$];
  int          period_beats[$];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #400000; $display("FAIL watchdog got=timeout expected=finish"); $fatal(1); end

  // Agent: samples at negedge, drives just after posedge; read data = address + beat index.
  initial begin
    a_waitrequest = 0; a_readdatavalid = 0; a_readdata = '0;
    forever begin
      @(negedge clk);
      if (a_read && !a_waitrequest) begin
        ag_addr.push_back(a_address);
        ag_len.push_back(a_burstcount == 0 ? 1 : int'(a_burstcount));
      end
      if (a_write && !a_waitrequest) begin
        wr_accepts++;
        if (exp_wr.size() == 0) chk_eq("wr_unexpected", exp_wr.size(), 1);
        else chk_eq("wr_data", a_writedata, exp_wr.pop_front());
        if (wr_accepts == stall_after) stall_cnt = 3;
      end
      @(posedge clk); #1;
      a_waitrequest = (stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
      a_readdatavalid = 0;
      if (ag_len.size() > 0) begin
        a_readdatavalid = 1;
        a_readdata = ag_addr[0] + 32'(ag_beat);
        ag_beat++;
        if (ag_beat == ag_len[0]) begin
          ag_beat = 0;
          void'(ag_addr.pop_front());
          void'(ag_len.pop_front());
        end
      end else if (inject_stray) begin
        a_readdatavalid = 1;
        a_readdata = 32'hDEAD_BEEF;
        inject_stray = 0;
      end
    end
  end

  // Read-beat scoreboard and grant history.
  initial forever begin
    @(negedge clk);
    if (h_readdatavalid[0]) begin
      rd_cnt0++; last_rd_cyc0 = cyc;
      if (exp_rd0.size() == 0) chk_eq("rd0_extra", exp_rd0.size(), 1);
      else chk_eq("rd0_data", h_readdata, exp_rd0.pop_front());
    end
    if (h_readdatavalid[1]) begin
      rd_cnt1++;
      if (exp_rd1.size() == 0) chk_eq("rd1_extra", exp_rd1.size(), 1);
      else chk_eq("rd1_data", h_readdata, exp_rd1.pop_front());
    end
    if (grant != prev_grant) begin
      if (grant != '0) grant_log.push_back(grant);
      else period_beats.push_back(cur_beats);
      cur_beats = 0;
    end
    if (|h_readdatavalid) cur_beats++;
    prev_grant = grant;
  end

  task automatic set_host(input int h, input logic rd, input logic wr,
                          input logic [31:0] addr, input int bc, input logic [31:0] wd);
    h_read[h] = rd; h_write[h] = wr;
    h_address[h*AW +: AW] = addr;
    h_burstcount[h*BW +: BW] = BW'(bc);
    h_writedata[h*DW +: DW] = wd;
  endtask

  task automatic host_read(input int h, input logic [31:0] addr, input int len);
    int n = 0;
    for (int i = 0; i < (len == 0 ? 1 : len); i++)
      if (h == 0) exp_rd0.push_back(addr + 32'(i)); else exp_rd1.push_back(addr + 32'(i));
    set_host(h, 1'b1, 1'b0, addr, len, '0);
    do begin @(negedge clk); n++; end while (h_waitrequest[h] && n < 400);
    if (h_waitrequest[h]) chk_eq("rd_cmd_timeout", h_waitrequest[h], 0);
    @(posedge clk); #1;
    set_host(h, 1'b0, 1'b0, '0, 0, '0);
  endtask

  task automatic host_write(input int h, input logic [31:0] addr, input int len,
                            input logic [31:0] base, output int stalls, output int first_cyc);
    int acc = 0, n = 0;
    stalls = 0; first_cyc = -1;
    set_host(h, 1'b0, 1'b1, addr, len, base);
    exp_wr.push_back(base);
    while (acc < len && n < 400) begin
      @(negedge clk); n++;
      if (!h_waitrequest[h]) begin
        acc++;
        if (first_cyc < 0) first_cyc = cyc;
        @(posedge clk); #1;
        if (acc < len) begin
          h_writedata[h*DW +: DW] = base + 32'(acc);
          exp_wr.push_back(base + 32'(acc));
        end
      end else stalls++;
    end
    if (acc < len) chk_eq("wr_timeout", acc, len);
    set_host(h, 1'b0, 1'b0, '0, 0, '0);
    @(negedge clk);
    chk_eq("wr_idle_after_last", grant, 0);
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((exp_rd0.size() + exp_rd1.size() + ag_len.size() + exp_wr.size()) != 0 && n < 600) begin
      @(negedge clk); n++;
    end
    chk_eq(tag, exp_rd0.size() + exp_rd1.size() + ag_len.size() + exp_wr.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int st, fc, n, base;
    logic [NREQ-1:0] exp_g [4];
    rst_n = 0; h_read = '0; h_write = '0; h_address = '0; h_burstcount = '0; h_writedata = '0;

    // Reset values
    @(negedge clk);
    chk_eq("rst_grant", grant, 0);
    chk_eq("rst_a_read", a_read, 0);
    chk_eq("rst_a_write", a_write, 0);
    chk_eq("rst_waitreq", h_waitrequest, 2'b11);
    chk_eq("rst_rdvalid", h_readdatavalid, 0);
    chk_eq("rst_err_stray", err_stray, 0);
    @(negedge clk); rst_n = 1;

    // Two hosts reading bursts of 16 back to back
    grant_log.delete(); period_beats.delete();
    @(posedge clk); #1;
    fork
      begin host_read(0, 32'h1000, 16); host_read(0, 32'h2000, 16); end
      begin host_read(1, 32'h3000, 16); host_read(1, 32'h4000, 16); end
    join
    wait_drained("t1_drain");
`ifdef AVALON_ARB_PRIORITY_EN
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b10};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 4; i++) begin
      chk_eq("t1_grant_seq", grant_log.size() > i ? grant_log[i] : 2'b00, exp_g[i]);
      chk_eq("t1_beats_per_grant", period_beats.size() > i ? period_beats[i] : 0, 16);
    end

    // Write burst of 4 with a 3-cycle agent stall on beat 2
    wr_accepts = 0; stall_after = 1;
    @(posedge clk); #1;
    host_write(1, 32'h9000, 4, 32'hA0, st, fc);
    stall_after = -1;
    chk_eq("t2_accepts", wr_accepts, 4);
    chk_eq("t2_stall_cycles", st, 4);
    chk_eq("t2_wr_drained", exp_wr.size(), 0);

    // Host 0 read of 8 while host 1 write is pending
    @(posedge clk); #1;
    fork
      host_read(0, 32'hB000, 8);
      host_write(1, 32'hC000, 2, 32'hC0, st, fc);
    join
    wait_drained("t3_drain");
    chk_eq("t3_grant_latency", fc - last_rd_cyc0, 2);

    // Stray read beat in IDLE
    chk_eq("t4_err_before", err_stray, 0);
    inject_stray = 1;
    @(negedge clk);
    chk_eq("t4_no_strobe", h_readdatavalid, 0);
    @(negedge clk);
    chk_eq("t4_err_set", err_stray, 1);
    repeat (5) @(negedge clk);
    chk_eq("t4_err_sticky", err_stray, 1);

    // burstcount 0 behaves as a single beat
    @(posedge clk); #1;
    host_read(1, 32'h8000, 0);
    wait_drained("bc0_drain");
    chk_eq("bc0_idle", grant, 0);

    // Reset after the 3rd of 16 beats
    pulse_reset();
    @(posedge clk); #1;
    base = rd_cnt0;
    host_read(0, 32'h5000, 16);
    n = 0;
    while (rd_cnt0 < base + 3 && n < 200) begin @(negedge clk); #1; n++; end
    chk_eq("t5_three_beats", rd_cnt0 - base, 3);
    rst_n = 0;
    exp_rd0.delete();
    #1;
    chk_eq("t5_rst_grant", grant, 0);
    chk_eq("t5_rst_waitreq", h_waitrequest, 2'b11);
    chk_eq("t5_rst_a_read", a_read, 0);
    chk_eq("t5_rst_err", err_stray, 0);
    repeat (2) @(negedge clk);
    chk_eq("t5_rst_rdvalid", h_readdatavalid, 0);
    rst_n = 1;
    wait_drained("t5_drain");
    chk_eq("t5_err_after", err_stray, 1);
    grant_log.delete();
    @(posedge clk); #1;
    fork
      host_read(0, 32'h6000, 2);
      host_read(1, 32'h7000, 2);
    join
    wait_drained("t5b_drain");
    chk_eq("t5_first_grant", grant_log.size() > 0 ? grant_log[0] : 2'b00, 2'b01);

    // Both hosts requesting continuously
    pulse_reset();
    grant_log.delete();
    @(posedge clk); #1;
    fork
      begin host_read(0, 32'hD000, 2); host_read(0, 32'hD100, 2); host_read(0, 32'hD200, 2); end
      host_read(1, 32'hE000, 2);
    join
    wait_drained("t6_drain");
`ifdef AVALON_ARB_PRIORITY_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b01};
`endif
    for (int i = 0; i < 4; i++)
      chk_eq("t6_grant_seq", grant_log.size() > i ? grant_log[i] : 2'b00, exp_g[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
